// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signals of the hazard/stall unit: decoded instruction words in,
// stall request and multdiv status out.
interface hazard_stall_unit_if;
    logic [31:0] fd_insn;
    logic [31:0] dx_insn;
    logic        dx_valid;
    logic        multdiv_RDY;
    logic        stall;
    logic        lw_hazard;
    logic        md_hazard;
    logic        md_busy;
    logic [4:0]  md_rd;
    logic        md_timeout;

    modport master (
        output fd_insn, dx_insn, dx_valid, multdiv_RDY,
        input  stall, lw_hazard, md_hazard, md_busy, md_rd, md_timeout
    );

    modport slave (
        input  fd_insn, dx_insn, dx_valid, multdiv_RDY,
        output stall, lw_hazard, md_hazard, md_busy, md_rd, md_timeout
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall generator for load-use and multiplier/divider hazards. A load-use hazard
// holds F/D for LOAD_STALLS cycles; a mul/div keeps stalling until RDY or timeout.
module hazard_stall_unit #(
    parameter int unsigned LOAD_STALLS  = 1,
    parameter int unsigned MD_STALL_ALL = 1,
    parameter int unsigned MD_TIMEOUT   = 64
) (
    input  logic               clock,
    input  logic               reset,
    hazard_stall_unit_if.slave hs
);
    localparam logic [4:0] OP_RTYPE  = 5'b00000;
    localparam logic [4:0] OP_LW     = 5'b01000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;
    localparam logic [1:0] LD_RELOAD = 2'(LOAD_STALLS - 1);
    localparam logic [7:0] MD_LAST   = 8'(MD_TIMEOUT - 1);
    localparam logic       STALL_ALL = (MD_STALL_ALL != 0);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    md_state_e  state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic [1:0] ld_cnt_q, ld_cnt_d;
    logic [4:0] md_rd_q, md_rd_d;
    logic       md_timeout_q, md_timeout_d;

    logic [4:0] fd_op, fd_rs1, fd_rs2, fd_alu;
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic       fd_rtype, fd_md, dx_lw, dx_md;
    logic       lw_det, md_dep, md_busy;
    logic       unused_insn_bits;

    // A zero index never creates a dependence; rs2 only counts for R-type.
    function automatic logic reads_src(input logic [4:0] r, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic rtype);
        return (r != 5'd0) && ((r == rs1) || (rtype && (r == rs2)));
    endfunction

    assign fd_op  = hs.fd_insn[31:27];
    assign fd_rs1 = hs.fd_insn[21:17];
    assign fd_rs2 = hs.fd_insn[16:12];
    assign fd_alu = hs.fd_insn[6:2];
    assign dx_op  = hs.dx_insn[31:27];
    assign dx_rd  = hs.dx_insn[26:22];
    assign dx_alu = hs.dx_insn[6:2];

    assign unused_insn_bits = ^{hs.fd_insn[26:22], hs.fd_insn[11:7], hs.fd_insn[1:0],
                                hs.dx_insn[21:7], hs.dx_insn[1:0]};

    assign fd_rtype = (fd_op == OP_RTYPE);
    assign fd_md    = fd_rtype && ((fd_alu == ALU_MUL) || (fd_alu == ALU_DIV));
    assign dx_lw    = (dx_op == OP_LW);
    assign dx_md    = (dx_op == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));

    assign lw_det  = hs.dx_valid && dx_lw && reads_src(dx_rd, fd_rs1, fd_rs2, fd_rtype);
    assign md_dep  = fd_md || reads_src(md_rd_q, fd_rs1, fd_rs2, fd_rtype);
    assign md_busy = (state_q == MD_BUSY);

    // RDY releases the stall in the same cycle it arrives.
    assign hs.lw_hazard  = lw_det || (ld_cnt_q != 2'd0);
    assign hs.md_hazard  = md_busy && !hs.multdiv_RDY && (STALL_ALL || md_dep);
    assign hs.stall      = hs.lw_hazard || hs.md_hazard;
    assign hs.md_busy    = md_busy;
    assign hs.md_rd      = md_rd_q;
    assign hs.md_timeout = md_timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= MD_IDLE;
            md_cnt_q     <= 8'd0;
            ld_cnt_q     <= 2'd0;
            md_rd_q      <= 5'd0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            ld_cnt_q     <= ld_cnt_d;
            md_rd_q      <= md_rd_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Extra load bubbles after the detecting cycle.
    always_comb begin
        ld_cnt_d = ld_cnt_q;
        if (lw_det && (ld_cnt_q == 2'd0)) begin
            ld_cnt_d = LD_RELOAD;
        end else if (ld_cnt_q != 2'd0) begin
            ld_cnt_d = ld_cnt_q - 2'd1;
        end
    end

    // Multdiv tracker; RDY wins over a coincident timeout.
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_rd_d      = md_rd_q;
        md_timeout_d = md_timeout_q;
        case (state_q)
            MD_IDLE: begin
                if (hs.dx_valid && dx_md) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = 8'd0;
                    md_rd_d  = dx_rd;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q + 8'd1;
                if (hs.multdiv_RDY) begin
                    state_d = MD_IDLE;
                end else if (md_cnt_q == MD_LAST) begin
                    state_d      = MD_IDLE;
                    md_timeout_d = 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end
endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter LOAD_STALLS, default 1, meaning number of bubble cycles per load-use hazard; legal range 1-3.
REQ-002 Parameter MD_STALL_ALL, default 1, meaning 1 = stall every instruction while the multiplier/divider is busy, 0 = stall only on dependence or on a structural conflict.
REQ-003 Parameter MD_TIMEOUT, default 64, meaning the maximum number of busy cycles before the multdiv FSM is aborted; legal range 2-255.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fd_insn  in  32  instruction in F/D; rs1 = [21:17], rs2 = [16:12], opcode = [31:27].
REQ-007 dx_insn  in  32  instruction in D/X; rd = [26:22], opcode = [31:27], ALU op = [6:2].
REQ-008 dx_valid  in  1  D/X holds a real instruction, not a bubble.
REQ-009 multdiv_RDY  in  1  the multiplier/divider result is ready (one-cycle pulse).
REQ-010 stall  out  1  hold PC and F/D, and insert a bubble into D/X.
REQ-011 lw_hazard  out  1  the current stall cause includes load-use.
REQ-012 md_hazard  out  1  the current stall cause includes multdiv.
REQ-013 md_busy  out  1  the multdiv FSM is in BUSY.
REQ-014 md_rd  out  5  the destination register of the in-flight mul/div.
REQ-015 md_timeout  out  1  sticky flag; a timeout occurred.

Function
REQ-016 Decode SHALL be as follows: R-type = opcode 00000; lw = opcode 01000; mul = R-type with ALU op 00110; div = R-type with ALU op 00111.
REQ-017 The fd instruction SHALL be treated as reading rs1 always, and as reading rs2 only when it is R-type.
REQ-018 A source register index of 0 SHALL never produce a hazard.
REQ-019 lw_det SHALL be dx_valid && dx lw && dx_rd != 0 && (dx_rd == rs1 || (R-type && dx_rd == rs2)), computed combinationally.
REQ-020 Load counter ld_cnt (2 bits) SHALL behave as follows: when lw_det && ld_cnt == 0, load LOAD_STALLS-1; otherwise, if ld_cnt != 0, decrement.
REQ-021 lw_hazard SHALL equal lw_det || ld_cnt != 0; with LOAD_STALLS = N, exactly N consecutive stall cycles result per hazard.
REQ-022 The multdiv FSM states SHALL be IDLE and BUSY.
REQ-023 IDLE -> BUSY SHALL occur when dx_valid && (mul || div); on that transition, latch md_rd = dx_rd and clear md_cnt to 0.
REQ-024 multdiv_RDY received in IDLE SHALL be ignored.
REQ-025 In BUSY, md_cnt (8 bits) SHALL increment each cycle.
REQ-026 BUSY -> IDLE SHALL occur on multdiv_RDY.
REQ-027 BUSY -> IDLE SHALL also occur when md_cnt == MD_TIMEOUT-1 without RDY; in that case set md_timeout, which stays set until reset.
REQ-028 RDY and timeout in the same cycle SHALL be treated as a normal completion, with md_timeout not set.
REQ-029 md_busy SHALL equal (state == BUSY).
REQ-030 With MD_STALL_ALL = 1, md_hazard SHALL equal md_busy && !multdiv_RDY.
REQ-031 With MD_STALL_ALL = 0, md_hazard SHALL equal md_busy && !multdiv_RDY && (fd is mul/div || (md_rd != 0 && (md_rd == rs1 || (R-type && md_rd == rs2)))).
REQ-032 The cycle in which multdiv_RDY is high SHALL release the stall combinationally (zero-cycle release).
REQ-033 stall SHALL equal lw_hazard || md_hazard; when both causes are present, both flags SHALL assert.
REQ-034 Outputs SHALL have no dependence on any clock edge other than clock, and there SHALL be no latches.

Reset
REQ-035 On reset, the FSM SHALL go to IDLE, with md_cnt = 0, ld_cnt = 0, md_rd = 0 and md_timeout = 0.
REQ-036 Following reset, stall, lw_hazard, md_hazard and md_busy SHALL read 0 whenever the inputs present no hazard.
REQ-037 Reset asserted mid-BUSY or mid-load-stall SHALL abort the operation in the next cycle, with no stall after reset releases.

Verification
REQ-038 Scenario: dx = lw r5, fd = add r1,r5,r2, LOAD_STALLS = 1 -> stall = 1 for exactly 1 cycle, and lw_hazard = 1.
REQ-039 Scenario: dx = lw r0, fd reads r0 -> stall = 0. Scenario: dx = lw r5, fd = addi reading r5 only in its rs2 position -> stall = 0.
REQ-040 Scenario: LOAD_STALLS = 3, lw hazard -> stall high for exactly 3 cycles, with ld_cnt sequence 2, 1, 0.
REQ-041 Scenario: MD_STALL_ALL = 1, dx = mul r7, RDY arrives 10 cycles later -> md_busy high 10 cycles, stall low in the RDY cycle, md_rd = 7.
REQ-042 Scenario: MD_STALL_ALL = 0, busy on r7 -> independent fd add r1,r2,r3 gives stall = 0; dependent add r1,r7,r2 gives stall = 1; fd div gives stall = 1.
REQ-043 Scenario: MD_TIMEOUT = 8, no RDY -> BUSY for 8 cycles, then IDLE with md_timeout = 1 held until reset; reset issued during BUSY -> md_busy = 0 in the next cycle.
